// File: rtl/gba_link_serial_if.sv
// Core-side control bundle for the GBA link serial engine.
// master modport = core logic issuing transfers, slave modport = the engine.
interface gba_link_serial_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  start;
  logic                  is_master;
  logic                  abort;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;

  modport master (
    output enable, start, is_master, abort, tx_data,
    input  rx_data, busy, done, timeout_err
  );

  modport slave (
    input  enable, start, is_master, abort, tx_data,
    output rx_data, busy, done, timeout_err
  );
endinterface

// File: rtl/gba_link_serial.sv
// GBA link-port normal-mode serial engine: MSB-first shift over SCK/SI/SO,
// acting as SCK master (divided clk) or SCK slave (synchronised pin).
//   state  | meaning
//   IDLE   | pins idle high, waiting for start & enable
//   MASTER | driving SCK, shifting on internal edges
//   SLAVE  | following external SCK, watchdog armed after first edge
//   DONE   | one-cycle completion, done pulse
module gba_link_serial #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_DIV     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  gba_link_serial_if.slave   core,
  input  logic               sck_from_gba,
  output logic               sck_to_gba,
  output logic               sck_is_to_gba,
  input  logic               si_from_gba,
  output logic               si_is_to_gba,
  output logic               so_to_gba,
  output logic               so_is_to_gba
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PHASE_TOP = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WD_TOP    = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MASTER, SLAVE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   sr, rx_q, sr_shift;
  logic [CW-1:0]           bit_cnt;
  logic [PW-1:0]           phase;
  logic [WW-1:0]           wd;
  logic                    started, sck_q, so_q, so_en_q, timeout_q, sck_prev;
  logic [SYNC_STAGES-1:0]  sck_sync, si_sync;
  logic                    sck_s, si_s, s_fall, s_rise, last, stop;
  logic                    load, do_fall, do_rise, wd_hit;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign s_fall   = sck_prev & ~sck_s;
  assign s_rise   = ~sck_prev & sck_s;
  assign sr_shift = {sr[DATA_WIDTH-2:0], si_s};
  assign last     = (bit_cnt == LAST_BIT);
  assign stop     = core.abort | ~core.enable;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // abort/disable is checked first so it wins over a completing edge
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_fall   = 1'b0;
    do_rise   = 1'b0;
    wd_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (core.start && core.enable) begin
          load      = 1'b1;
          state_nxt = core.is_master ? MASTER : SLAVE;
        end
      end
      MASTER: begin
        if (stop) state_nxt = IDLE;
        else if (phase == '0) begin
          if (sck_q) do_fall = 1'b1;
          else begin
            do_rise = 1'b1;
            if (last) state_nxt = DONE;
          end
        end
      end
      SLAVE: begin
        if (stop) state_nxt = IDLE;
        else if (s_fall) do_fall = 1'b1;
        else if (s_rise) begin
          do_rise = 1'b1;
          if (last) state_nxt = DONE;
        end else if (started && wd == '0) begin
          wd_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr        <= '0;
      rx_q      <= '0;
      bit_cnt   <= '0;
      phase     <= '0;
      wd        <= '0;
      started   <= 1'b0;
      sck_q     <= 1'b1;
      so_q      <= 1'b1;
      so_en_q   <= 1'b0;
      timeout_q <= 1'b0;
      sck_prev  <= 1'b1;
      sck_sync  <= '1;
      si_sync   <= '1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_from_gba};
      si_sync   <= {si_sync[SYNC_STAGES-2:0], si_from_gba};
      sck_prev  <= sck_s;
      so_en_q   <= core.enable;
      timeout_q <= wd_hit;
      if (load) begin
        sr      <= core.tx_data;
        bit_cnt <= '0;
        phase   <= PHASE_TOP;
        wd      <= WD_TOP;
        started <= 1'b0;
      end
      if (state == MASTER) phase <= (phase == '0) ? PHASE_TOP : phase - 1'b1;
      // watchdog only runs once the external master has produced an edge
      if (state == SLAVE) begin
        if (s_fall || s_rise) begin
          started <= 1'b1;
          wd      <= WD_TOP;
        end else if (started && wd != '0) begin
          wd <= wd - 1'b1;
        end
      end
      if (do_fall) begin
        so_q <= sr[DATA_WIDTH-1];
        if (state == MASTER) sck_q <= 1'b0;
      end
      if (do_rise) begin
        sr      <= sr_shift;
        bit_cnt <= bit_cnt + 1'b1;
        if (state == MASTER) sck_q <= 1'b1;
        if (last) rx_q <= sr_shift;
      end
      if (state_nxt == IDLE) begin
        sck_q <= 1'b1;
        so_q  <= 1'b1;
      end
    end
  end

  assign core.busy        = (state == MASTER) || (state == SLAVE);
  assign core.done        = (state == DONE);
  assign core.timeout_err = timeout_q;
  assign core.rx_data     = rx_q;
  assign sck_to_gba       = sck_q;
  assign sck_is_to_gba    = (state == MASTER) && core.enable;
  assign si_is_to_gba     = 1'b0;
  assign so_to_gba        = so_q;
  assign so_is_to_gba     = so_en_q;
endmodule
